// File: rtl/mem_arbiter.sv
// Two-port arbiter for a shared unified memory: a CPU port and a DMA/loader port.
// A grant is held for exactly LATENCY cycles, and ties alternate between the two ports.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DMA = 2'd2
  } state_t;

  typedef enum logic {
    LAST_CPU = 1'b0,
    LAST_DMA = 1'b1
  } owner_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  owner_t      last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        acc_we_q, acc_we_d;
  logic [31:0] cpu_rdata_q, dma_rdata_q;
  logic [31:0] ret_data;

  // Writes return zero; the direction is latched at grant time.
  assign ret_data = acc_we_q ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= LAST_DMA;
      cnt_q       <= '0;
      acc_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      acc_we_q <= acc_we_d;
      if (cpu_ready) cpu_rdata_q <= ret_data;
      if (dma_ready) dma_rdata_q <= ret_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    acc_we_d  = acc_we_q;
    gnt       = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    cpu_ready = 1'b0;
    dma_ready = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On a tie the CPU wins only if the DMA port was served last.
        if (cpu_req && (!dma_req || last_q == LAST_DMA)) begin
          state_d  = BUSY_CPU;
          last_d   = LAST_CPU;
          acc_we_d = cpu_we;
        end else if (dma_req) begin
          state_d  = BUSY_DMA;
          last_d   = LAST_DMA;
          acc_we_d = dma_we;
        end
      end

      BUSY_CPU: begin
        gnt       = 2'b01;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we && (cnt_q == '0);
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          cpu_ready = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end

      BUSY_DMA: begin
        gnt       = 2'b10;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we && (cnt_q == '0);
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          dma_ready = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign cpu_rdata = cpu_ready ? ret_data : cpu_rdata_q;
  assign dma_rdata = dma_ready ? ret_data : dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=2 instance for the main scenarios,
// LATENCY=1 instance for back-to-back CPU accesses.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ready, dma_ready, mem_we;
  logic [1:0]  gnt;

  logic        b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_cpu_ready, b_dma_ready, b_mem_we;
  logic [1:0]  b_gnt;

  // Memory models: read data is a fixed function of the address.
  assign mem_rdata   = (mem_addr == 32'h10) ? 32'hDEADBEEF : mem_addr + 32'h1000;
  assign b_mem_rdata = b_mem_addr + 32'h1000;

  mem_arbiter #(.LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .gnt(gnt)
  );

  mem_arbiter #(.LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_ready(b_dma_ready),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata),
    .gnt(b_gnt)
  );

  typedef struct packed {
    logic        dma;
    logic [31:0] data;
  } exp_t;

  exp_t        qa[$];
  logic [31:0] qb[$];
  exp_t        ea;
  logic [31:0] eb;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ready pulse pops one expectation; a pulse with nothing queued is an error.
  always @(negedge clk) begin
    check("gnt_legal", 64'(gnt == 2'b11), 64'd0);
    check("b_gnt_legal", 64'(b_gnt == 2'b11), 64'd0);
    if (cpu_ready || dma_ready) begin
      if (qa.size() == 0) ea = '0;
      else ea = qa.pop_front();
      check("a_ready", {30'd0, dma_ready, cpu_ready, dma_ready ? dma_rdata : cpu_rdata},
            {30'd0, ea.dma, ~ea.dma, ea.data});
    end
    if (b_cpu_ready || b_dma_ready) begin
      if (qb.size() == 0) begin
        check("b_ready_unexpected", {30'd0, b_dma_ready, b_cpu_ready, b_cpu_rdata}, 64'd0);
      end else begin
        eb = qb.pop_front();
        check("b_ready", {30'd0, b_dma_ready, b_cpu_ready, b_cpu_rdata}, {30'd0, 2'b01, eb});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  logic [1:0] gnt_tbl [12] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0,
                               2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0};

  initial begin
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = '0; b_dma_wdata = '0;

    // Reset values
    #3;
    check("rst_gnt", gnt, 2'b00);
    check("rst_mem", {mem_we, mem_addr, mem_wdata}, '0);
    check("rst_ready", {cpu_ready, dma_ready}, 2'b00);
    check("rst_rdata", {cpu_rdata, dma_rdata}, '0);
    check("rst_b_gnt", b_gnt, 2'b00);
    step(); step();
    rst = 1'b1;
    step();

    // CPU read, LATENCY=2
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    qa.push_back('{dma: 1'b0, data: 32'hDEADBEEF});
    step();
    check("cpu_rd_gnt", gnt, 2'b01);
    check("cpu_rd_addr", mem_addr, 32'h10);
    check("cpu_rd_we", mem_we, 1'b0);
    step();
    cpu_req = 0;
    step();
    check("cpu_rd_done_gnt", gnt, 2'b00);
    check("idle_mem_addr", mem_addr, 32'h0);
    step();
    check("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // DMA write; CPU inputs toggle without a request
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
    cpu_addr = 32'h999; cpu_wdata = 32'h5555AAAA;
    qa.push_back('{dma: 1'b1, data: 32'h0});
    step();
    check("dma_wr_gnt", gnt, 2'b10);
    check("dma_wr_strobe", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h40, 32'h12345678});
    dma_req = 0;
    step();
    check("dma_wr_strobe_off", {mem_we, mem_addr}, {1'b0, 32'h40});
    step();
    check("dma_wr_done_gnt", gnt, 2'b00);
    check("dma_wr_rdata", dma_rdata, 32'h0);
    check("cpu_rdata_untouched", cpu_rdata, 32'hDEADBEEF);

    // Both requesting from reset release: CPU, DMA, CPU, DMA
    rst = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    dma_req = 1; dma_we = 0; dma_addr = 32'h30;
    qa.push_back('{dma: 1'b0, data: 32'h1020});
    qa.push_back('{dma: 1'b1, data: 32'h1030});
    qa.push_back('{dma: 1'b0, data: 32'h1020});
    qa.push_back('{dma: 1'b1, data: 32'h1030});
    step();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("rr_gnt_%0d", k), gnt, gnt_tbl[k]);
    end
    cpu_req = 0; dma_req = 0;

    // Reset mid-access (CPU write, cnt=0) without a clock edge
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'hCAFEF00D;
    step();
    check("abort_pre_gnt", {gnt, mem_we}, {2'b01, 1'b1});
    #2;
    rst = 1'b0;
    cpu_req = 0;
    #1;
    check("abort_gnt", gnt, 2'b00);
    check("abort_mem", {mem_we, mem_addr, mem_wdata}, '0);
    check("abort_ready", {cpu_ready, dma_ready}, 2'b00);
    check("abort_rdata", {cpu_rdata, dma_rdata}, '0);
    step();
    rst = 1'b1;
    repeat (4) step();
    check("abort_after_gnt", gnt, 2'b00);

    // LATENCY=1, CPU request held: ready every second cycle, address tracks live input
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h100;
    qb.push_back(32'h1110);
    qb.push_back(32'h1130);
    qb.push_back(32'h1150);
    qb.push_back(32'h1170);
    for (int k = 1; k <= 8; k++) begin
      step();
      b_cpu_addr = 32'h100 + 32'(16 * k);
      #1;
      if (k % 2 == 1) begin
        check($sformatf("b_busy_%0d", k), {b_gnt, b_mem_addr}, {2'b01, 32'h100 + 32'(16 * k)});
      end else begin
        check($sformatf("b_idle_%0d", k), {b_gnt, b_mem_addr}, {2'b00, 32'h0});
      end
    end
    b_cpu_req = 0;
    repeat (3) step();

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
